// File: rtl/out_packet_scheduler_if.sv
// Request, sender and status signals between the packet sources, the scheduler and Sender.
// The scheduler uses the master modport; the surrounding logic uses the slave modport.
interface out_packet_scheduler_if;
  logic        power_on_req;
  logic        audio_req;
  logic        aux_req;
  logic [39:0] aux_data;
  logic        aux_ack;
  logic        sender_busy;
  logic [39:0] out_data;
  logic        out_valid;
  logic [2:0]  grant;
  logic [7:0]  audio_drop_cnt;

  modport master (
    input  power_on_req, audio_req, aux_req, aux_data, sender_busy,
    output aux_ack, out_data, out_valid, grant, audio_drop_cnt
  );

  modport slave (
    output power_on_req, audio_req, aux_req, aux_data, sender_busy,
    input  aux_ack, out_data, out_valid, grant, audio_drop_cnt
  );
endinterface

// File: rtl/out_packet_scheduler.sv
// Shares the outbound monitor-link Sender between power-on, audio-request and aux packets.
// Optional `define AUDIO_RR_EN: round-robin between audio and aux (power_on stays highest).
module out_packet_scheduler #(
  parameter logic [39:0] PKT_POWER_ON  = 40'hC7_0000_0000,
  parameter logic [39:0] PKT_AUDIO_REQ = 40'h07_0000_0000,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned BUSY_TIMEOUT  = 4
) (
  input logic                    i_mon_clk,
  input logic                    i_rst_n,
  out_packet_scheduler_if.master bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StSend, StGap} state_e;

  state_e      r_state;
  logic [2:0]  r_pend;
  logic [39:0] r_aux_data;
  logic [39:0] r_out_data;
  logic        r_out_valid;
  logic        r_aux_ack;
  logic [2:0]  r_grant;
  logic [7:0]  r_drop_cnt;
  logic [15:0] r_cnt;
`ifdef AUDIO_RR_EN
  logic        r_rr_aux_first;
`endif

  logic [2:0]  w_req;
  logic [2:0]  w_clr;
  logic [2:0]  w_retry;
  logic [2:0]  w_pick;
  logic [39:0] w_pick_data;
  logic        w_busy_timeout;

  always_comb begin
    w_req          = {bus.aux_req, bus.audio_req, bus.power_on_req};
    w_clr          = (r_state == StIssue) ? r_grant : 3'b000;
    w_busy_timeout = (r_state == StWaitBusy) && !bus.sender_busy &&
                     (r_cnt == 16'(BUSY_TIMEOUT - 1));
    w_retry        = w_busy_timeout ? r_grant : 3'b000;

    w_pick = 3'b000;
    if (r_pend[0]) begin
      w_pick = 3'b001;
`ifdef AUDIO_RR_EN
    end else if (r_pend[1] && r_pend[2]) begin
      w_pick = r_rr_aux_first ? 3'b100 : 3'b010;
`endif
    end else if (r_pend[1]) begin
      w_pick = 3'b010;
    end else if (r_pend[2]) begin
      w_pick = 3'b100;
    end

    w_pick_data = r_aux_data;
    if (w_pick[0]) begin
      w_pick_data = PKT_POWER_ON;
    end else if (w_pick[1]) begin
      w_pick_data = PKT_AUDIO_REQ;
    end
  end

  always_ff @(posedge i_mon_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_pend      <= 3'b000;
      r_aux_data  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_aux_ack   <= 1'b0;
      r_grant     <= 3'b000;
      r_drop_cnt  <= 8'h00;
      r_cnt       <= '0;
`ifdef AUDIO_RR_EN
      r_rr_aux_first <= 1'b0;
`endif
    end else begin
      // A new request in the clearing cycle keeps the flag set.
      r_pend      <= (r_pend & ~w_clr) | w_retry | w_req;
      r_out_valid <= 1'b0;
      r_aux_ack   <= 1'b0;

      if (bus.aux_req) begin
        r_aux_data <= bus.aux_data;
      end
      if (bus.audio_req && r_pend[1] && !w_clr[1] && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'h01;
      end

      unique case (r_state)
        StIdle: begin
          if (|r_pend) begin
            r_grant     <= w_pick;
            r_out_data  <= w_pick_data;
            r_out_valid <= 1'b1;
            r_aux_ack   <= w_pick[2];
            r_state     <= StIssue;
`ifdef AUDIO_RR_EN
            if (w_pick[1]) begin
              r_rr_aux_first <= 1'b1;
            end else if (w_pick[2]) begin
              r_rr_aux_first <= 1'b0;
            end
`endif
          end
        end
        StIssue: begin
          r_cnt   <= '0;
          r_state <= StWaitBusy;
        end
        StWaitBusy: begin
          if (bus.sender_busy) begin
            r_state <= StSend;
          end else if (w_busy_timeout) begin
            r_cnt   <= '0;
            r_state <= StGap;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StSend: begin
          if (!bus.sender_busy) begin
            r_cnt   <= '0;
            r_state <= StGap;
          end
        end
        StGap: begin
          if (r_cnt == 16'(GAP_CYCLES - 1)) begin
            r_grant <= 3'b000;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.out_data       = r_out_data;
  assign bus.out_valid      = r_out_valid;
  assign bus.aux_ack        = r_aux_ack;
  assign bus.grant          = r_grant;
  assign bus.audio_drop_cnt = r_drop_cnt;

endmodule
